sop_match_pipe: RTL

- Parametrised, pipelined sum-of-products match unit.
- Each lane evaluates a set of qualified operand-pair products, split into groups. Group 0 is always enabled; each higher group is gated by a cumulative enable chain. The lane's products are OR-reduced to one hit bit.
- Generalises the four-lane combinational match logic in the benchmark set to LANES/TERMS/GROUPS, and adds:
  - a valid/ready pipeline,
  - a sticky accumulate mode,
  - per-lane saturating hit counters.
- Sits between the operand-capture front end and the decision/arbiter stage.

---
 rtl/sop_match_pkg.sv | 29 ++
 rtl/sop_match_lane.sv | 40 ++++
 rtl/sop_match_pipe.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/sop_match_pkg.sv
// Shared definitions for the sum-of-products match pipeline.
// Holds the default geometry, the lane/term flat-index helper, the
// per-lane group vector type and the default counter ceiling.
package sop_match_pkg;

   localparam int LANES_DEF  = 4;
   localparam int GROUPS_DEF = 4;
   localparam int TPG_DEF    = 6;
   localparam int CNT_W_DEF  = 16;

   // Terms per lane is always groups times terms-per-group.
   function automatic int terms_of(input int groups, input int tpg);
      return groups * tpg;
   endfunction

   localparam int TERMS_DEF = GROUPS_DEF * TPG_DEF;

   // Flat bit index of (lane, term) in the a/b/qual operand buses.
   function automatic int lt_idx(input int lane, input int term, input int terms);
      return lane * terms + term;
   endfunction

   // One bit per group: group OR already masked by its enable.
   typedef logic [GROUPS_DEF-1:0] grp_vec_t;

   // Saturation ceiling for the default counter width.
   localparam logic [CNT_W_DEF-1:0] CNT_MAX = {CNT_W_DEF{1'b1}};

endpackage

// File: rtl/sop_match_lane.sv
// Single-lane term/group reduction.
// Ports:
//   a, b, qual : TERMS operand and qualifier bits of this lane
//   grp_en     : GROUPS-1 enable chain links (bit g-1 gates group g)
//   grp_hit    : per-group OR of qualified products, masked by the
//                cumulative enable (group 0 always enabled)
module sop_match_lane
   import sop_match_pkg::*;
#(
   parameter int GROUPS = GROUPS_DEF,
   parameter int TPG    = TPG_DEF,
   parameter int TERMS  = GROUPS * TPG
) (
   input  logic [TERMS-1:0]  a,
   input  logic [TERMS-1:0]  b,
   input  logic [TERMS-1:0]  qual,
   input  logic [GROUPS-2:0] grp_en,
   output logic [GROUPS-1:0] grp_hit
);

   logic [TERMS-1:0] prod_s;

   // Product terms, group ORs and the running AND of the enable chain.
   always_comb begin
      logic en_v;
      prod_s  = a & b & qual;
      grp_hit = {GROUPS{1'b0}};
      en_v    = 1'b1;
      for (int g = 0; g < GROUPS; g++) begin
         grp_hit[g] = (|prod_s[g*TPG +: TPG]) & en_v;
         // A zero link kills this group's successor and everything beyond it.
         if (g < GROUPS - 1) begin
            en_v = en_v & grp_en[g];
         end else begin
            en_v = en_v;
         end
      end
   end

endmodule

// File: rtl/sop_match_pipe.sv
// Pipelined sum-of-products match unit.
// Stage 1 registers the masked group hits of every lane plus the sticky
// flag; stage 2 registers the per-lane hit (optionally OR-accumulated).
// Per-lane saturating counters count output handshakes with hit set.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand beat handshake
//   a, b, qual          : LANES*TERMS operand/qualifier bits
//   grp_en              : LANES*(GROUPS-1) enable-chain links
//   sticky              : accumulate hit with previous stage-2 hit
//   clear               : synchronous clear of accumulator and counters
//   out_valid/out_ready : result handshake
//   hit                 : per-lane match result
//   hit_cnt             : LANES*CNT_W saturating hit counters
module sop_match_pipe
   import sop_match_pkg::*;
#(
   parameter int LANES  = LANES_DEF,
   parameter int GROUPS = GROUPS_DEF,
   parameter int TPG    = TPG_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [LANES*terms_of(GROUPS,TPG)-1:0] a,
   input  logic [LANES*terms_of(GROUPS,TPG)-1:0] b,
   input  logic [LANES*terms_of(GROUPS,TPG)-1:0] qual,
   input  logic [LANES*(GROUPS-1)-1:0]       grp_en,
   input  logic                              sticky,
   input  logic                              clear,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [LANES-1:0]                  hit,
   output logic [LANES*CNT_W-1:0]            hit_cnt
);

   localparam int TERMS = terms_of(GROUPS, TPG);
   localparam logic [CNT_W-1:0] CNT_TOP = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [LANES*GROUPS-1:0] grp_hit_s;
   logic [LANES*GROUPS-1:0] s1_grp_r;
   logic                    s1_sticky_r;
   logic                    s1_valid_r;
   logic [LANES-1:0]        acc_r;
   logic [LANES-1:0]        raw_s;
   logic [LANES-1:0]        hit_next_s;
   logic                    s2_accept_s;
   logic                    out_hs_s;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      sop_match_lane #(
         .GROUPS (GROUPS),
         .TPG    (TPG),
         .TERMS  (TERMS)
      ) u_lane (
         .a       (a[lt_idx(l, 0, TERMS) +: TERMS]),
         .b       (b[lt_idx(l, 0, TERMS) +: TERMS]),
         .qual    (qual[lt_idx(l, 0, TERMS) +: TERMS]),
         .grp_en  (grp_en[l*(GROUPS-1) +: (GROUPS-1)]),
         .grp_hit (grp_hit_s[l*GROUPS +: GROUPS])
      );
   end

   // Handshake control; out_ready reaches in_ready combinationally only.
   always_comb begin
      s2_accept_s = ~out_valid | out_ready;
      in_ready    = ~s1_valid_r | s2_accept_s;
      out_hs_s    = out_valid & out_ready;
   end

   // Stage-2 hit: lane OR of masked groups, OR-ed with the accumulator in sticky mode.
   always_comb begin
      raw_s      = {LANES{1'b0}};
      hit_next_s = {LANES{1'b0}};
      for (int l = 0; l < LANES; l++) begin
         raw_s[l] = |s1_grp_r[l*GROUPS +: GROUPS];
      end
      if (s1_sticky_r) begin
         hit_next_s = raw_s | acc_r;
      end else begin
         hit_next_s = raw_s;
      end
   end

   // Stage 1 register: loads whenever it is empty or draining into stage 2.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_r  <= 1'b0;
         s1_grp_r    <= {(LANES*GROUPS){1'b0}};
         s1_sticky_r <= 1'b0;
      end else if (in_ready) begin
         s1_valid_r <= in_valid;
         if (in_valid) begin
            s1_grp_r    <= grp_hit_s;
            s1_sticky_r <= sticky;
         end
      end
   end

   // Stage 2 register: holds its beat while downstream stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         hit       <= {LANES{1'b0}};
      end else if (s2_accept_s) begin
         out_valid <= s1_valid_r;
         if (s1_valid_r) begin
            hit <= hit_next_s;
         end
      end
   end

   // Accumulator tracks the last stage-2 hit; clear restarts it without touching hit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_r <= {LANES{1'b0}};
      end else if (clear) begin
         acc_r <= {LANES{1'b0}};
      end else if (s2_accept_s && s1_valid_r) begin
         acc_r <= hit_next_s;
      end
   end

   // Saturating per-lane hit counters; clear takes priority over a handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt <= {(LANES*CNT_W){1'b0}};
      end else begin
         for (int l = 0; l < LANES; l++) begin
            if (clear) begin
               hit_cnt[l*CNT_W +: CNT_W] <= {CNT_W{1'b0}};
            end else if (out_hs_s && hit[l] && (hit_cnt[l*CNT_W +: CNT_W] != CNT_TOP)) begin
               hit_cnt[l*CNT_W +: CNT_W] <= hit_cnt[l*CNT_W +: CNT_W] + CNT_ONE;
            end
         end
      end
   end

endmodule
